// File: rtl/btb_wr_arb_pkg.sv
// Shared fetch definitions for the BTB write path: branch type
// encodings, target width and the write-request bundle.
package btb_wr_arb_pkg;

    localparam int TAR_W     = 64;
    localparam int BTB_IDX_W = 6;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_typ_e;

    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        logic                 vld;
        logic [2:0]           pos;
        br_typ_e              typ;
        logic [TAR_W-1:0]     tar;
    } wr_req_t;

endpackage

// File: rtl/btb_wr_fifo.sv
// Predecode write FIFO with a per-entry dead bit; an index-match kill
// marks stale entries so they drain without reaching the BTB.
module btb_wr_fifo
    import btb_wr_arb_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  wr_req_t          push_req_i,
    input  logic             pop_i,
    input  logic             kill_i,
    input  logic [IDX_W-1:0] kill_idx_i,
    output wr_req_t          head_o,
    output logic             head_dead_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    wr_req_t        mem [DEPTH];
    logic [DEPTH-1:0] dead;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    assign empty_o     = (wr_ptr == rd_ptr);
    assign full_o      = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_o      = mem[rd_ptr[AW-1:0]];
    assign head_dead_o = dead[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_i)
            mem[wr_ptr[AW-1:0]] <= push_req_i;
    end

    // Kill may tag free slots too; a push always clears its slot's tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dead   <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dead   <= '0;
        end else begin
            if (push_i)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_i)
                rd_ptr <= rd_ptr + PTR_ONE;
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_i && mem[i].idx == kill_idx_i)
                    dead[i] <= 1'b1;
            end
            if (push_i)
                dead[wr_ptr[AW-1:0]] <= 1'b0;
        end
    end

endmodule

// File: rtl/btb_wr_arb.sv
// BTB write-port arbiter: predecode FIFO vs execute resolution writes.
// Define BTB_WR_ARB_STATS_EN to add drop_cnt_o / kill_cnt_o counters.
module btb_wr_arb
    import btb_wr_arb_pkg::*;
#(
    parameter int IDX_W      = BTB_IDX_W,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             btb_rd_i,
    input  logic             fe_we_i,
    input  logic [IDX_W-1:0] fe_idx_i,
    input  logic [2:0]       fe_pos_i,
    input  logic [1:0]       fe_typ_i,
    input  logic [TAR_W-1:0] fe_tar_i,
    input  logic             ex_vld_i,
    output logic             ex_rdy_o,
    input  logic             ex_inv_i,
    input  logic [IDX_W-1:0] ex_idx_i,
    input  logic [2:0]       ex_pos_i,
    input  logic [1:0]       ex_typ_i,
    input  logic [TAR_W-1:0] ex_tar_i,
    output logic             btb_we_o,
    output logic [IDX_W-1:0] btb_idx_o,
    output logic             btb_vld_o,
    output logic [2:0]       btb_pos_o,
    output logic [1:0]       btb_typ_o,
    output logic [TAR_W-1:0] btb_tar_o,
    output logic             fifo_full_o
`ifdef BTB_WR_ARB_STATS_EN
    ,
    output logic [15:0]      drop_cnt_o,
    output logic [15:0]      kill_cnt_o
`endif
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);
    localparam logic [SW-1:0] S_ONE  = SW'(1);

    wr_req_t       fe_req;
    wr_req_t       ex_hold;
    wr_req_t       head;
    wr_req_t       sel;
    logic          ex_hold_v;
    logic          head_dead;
    logic          fifo_empty;
    logic          fifo_full;
    logic [SW-1:0] starve_cnt;
    logic          ex_acc;
    logic          kill_same;
    logic          fe_push;
    logic          fe_ok;
    logic          gnt_fe;
    logic          gnt_ex;

    assign fe_req = '{idx: fe_idx_i, vld: 1'b1, pos: fe_pos_i,
                      typ: br_typ_e'(fe_typ_i), tar: fe_tar_i};

    // A flush discards the FIFO, so its head is never granted that cycle.
    assign fe_ok  = !btb_rd_i && !fifo_empty && !flush_i;
    assign gnt_fe = fe_ok && (starve_cnt == SMAX || !ex_hold_v);
    assign gnt_ex = !btb_rd_i && ex_hold_v && !gnt_fe;

    assign ex_rdy_o  = !ex_hold_v || gnt_ex;
    assign ex_acc    = ex_vld_i && ex_rdy_o;
    assign kill_same = ex_acc && fe_we_i && (fe_idx_i == ex_idx_i);
    assign fe_push   = fe_we_i && !flush_i && !kill_same &&
                       (!fifo_full || gnt_fe);

    assign sel         = gnt_ex ? ex_hold : head;
    assign fifo_full_o = fifo_full;

    btb_wr_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (fe_push),
        .push_req_i  (fe_req),
        .pop_i       (gnt_fe),
        .kill_i      (ex_acc),
        .kill_idx_i  (ex_idx_i),
        .head_o      (head),
        .head_dead_o (head_dead),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_hold_v <= 1'b0;
            ex_hold   <= '0;
        end else if (ex_acc) begin
            ex_hold_v <= 1'b1;
            ex_hold   <= '{idx: ex_idx_i, vld: !ex_inv_i,
                           pos: ex_pos_i,
                           typ: br_typ_e'(ex_typ_i),
                           tar: ex_tar_i};
        end else if (gnt_ex) begin
            ex_hold_v <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            starve_cnt <= '0;
        else if (flush_i || fifo_empty || gnt_fe)
            starve_cnt <= '0;
        else if (starve_cnt != SMAX)
            starve_cnt <= starve_cnt + S_ONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btb_we_o  <= 1'b0;
            btb_idx_o <= '0;
            btb_vld_o <= 1'b0;
            btb_pos_o <= '0;
            btb_typ_o <= '0;
            btb_tar_o <= '0;
        end else begin
            btb_we_o <= gnt_ex || (gnt_fe && !head_dead);
            if (gnt_ex || gnt_fe) begin
                btb_idx_o <= sel.idx;
                btb_vld_o <= sel.vld;
                btb_pos_o <= sel.pos;
                btb_typ_o <= sel.typ;
                btb_tar_o <= sel.tar;
            end
        end
    end

`ifdef BTB_WR_ARB_STATS_EN
    logic drop_ev;

    assign drop_ev = fe_we_i && !flush_i &&
                     (kill_same || (fifo_full && !gnt_fe));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
            kill_cnt_o <= '0;
        end else begin
            if (drop_ev && drop_cnt_o != 16'hffff)
                drop_cnt_o <= drop_cnt_o + 16'd1;
            if (gnt_fe && head_dead)
                kill_cnt_o <= kill_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_wr_arb.sv
// Bench for btb_wr_arb: vector table, scoreboard of expected BTB
// writes, and sequences for kill, starvation, flush and reset.
module tb_btb_wr_arb;
    import btb_wr_arb_pkg::*;

    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          btb_rd_i;
    logic          fe_we_i;
    logic [IW-1:0] fe_idx_i;
    logic [2:0]    fe_pos_i;
    logic [1:0]    fe_typ_i;
    logic [63:0]   fe_tar_i;
    logic          ex_vld_i;
    logic          ex_rdy_o;
    logic          ex_inv_i;
    logic [IW-1:0] ex_idx_i;
    logic [2:0]    ex_pos_i;
    logic [1:0]    ex_typ_i;
    logic [63:0]   ex_tar_i;
    logic          btb_we_o;
    logic [IW-1:0] btb_idx_o;
    logic          btb_vld_o;
    logic [2:0]    btb_pos_o;
    logic [1:0]    btb_typ_o;
    logic [63:0]   btb_tar_o;
    logic          fifo_full_o;
`ifdef BTB_WR_ARB_STATS_EN
    logic [15:0]   drop_cnt_o;
    logic [15:0]   kill_cnt_o;
`endif

    btb_wr_arb dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .btb_rd_i    (btb_rd_i),
        .fe_we_i     (fe_we_i),
        .fe_idx_i    (fe_idx_i),
        .fe_pos_i    (fe_pos_i),
        .fe_typ_i    (fe_typ_i),
        .fe_tar_i    (fe_tar_i),
        .ex_vld_i    (ex_vld_i),
        .ex_rdy_o    (ex_rdy_o),
        .ex_inv_i    (ex_inv_i),
        .ex_idx_i    (ex_idx_i),
        .ex_pos_i    (ex_pos_i),
        .ex_typ_i    (ex_typ_i),
        .ex_tar_i    (ex_tar_i),
        .btb_we_o    (btb_we_o),
        .btb_idx_o   (btb_idx_o),
        .btb_vld_o   (btb_vld_o),
        .btb_pos_o   (btb_pos_o),
        .btb_typ_o   (btb_typ_o),
        .btb_tar_o   (btb_tar_o),
        .fifo_full_o (fifo_full_o)
`ifdef BTB_WR_ARB_STATS_EN
        ,
        .drop_cnt_o  (drop_cnt_o),
        .kill_cnt_o  (kill_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic          vld;
        logic [2:0]    pos;
        logic [1:0]    typ;
        logic [63:0]   tar;
        int            due;
    } exp_t;

    typedef struct {
        logic          is_ex;
        logic          inv;
        logic [IW-1:0] idx;
        logic [2:0]    pos;
        logic [1:0]    typ;
        logic [63:0]   tar;
        logic          exp_vld;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t e;
    always @(negedge clk) begin
        if (!rst_i && btb_we_o) begin
            wr_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got idx=%0d at cyc %0d, required no write",
                         btb_idx_o, cyc);
            end else begin
                e = sb.pop_front();
                if (btb_idx_o !== e.idx || btb_vld_o !== e.vld ||
                    btb_pos_o !== e.pos || btb_typ_o !== e.typ ||
                    btb_tar_o !== e.tar || (e.due >= 0 && cyc != e.due)) begin
                    errors++;
                    $display("FAIL sb_write: got idx=%0d vld=%0d pos=%0d typ=%0d tar=%h cyc=%0d, required idx=%0d vld=%0d pos=%0d typ=%0d tar=%h cyc=%0d",
                             btb_idx_o, btb_vld_o, btb_pos_o, btb_typ_o, btb_tar_o, cyc,
                             e.idx, e.vld, e.pos, e.typ, e.tar, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush_i  = 1'b0;
        btb_rd_i = 1'b0;
        fe_we_i  = 1'b0;
        fe_idx_i = '0;
        fe_pos_i = '0;
        fe_typ_i = '0;
        fe_tar_i = '0;
        ex_vld_i = 1'b0;
        ex_inv_i = 1'b0;
        ex_idx_i = '0;
        ex_pos_i = '0;
        ex_typ_i = '0;
        ex_tar_i = '0;
    endtask

    task automatic fe(input logic [IW-1:0] i, input logic [2:0] p,
                      input logic [1:0] t, input logic [63:0] a);
        fe_we_i = 1'b1; fe_idx_i = i; fe_pos_i = p;
        fe_typ_i = t;   fe_tar_i = a;
    endtask

    task automatic ex(input logic inv, input logic [IW-1:0] i,
                      input logic [2:0] p, input logic [1:0] t,
                      input logic [63:0] a);
        ex_vld_i = 1'b1; ex_inv_i = inv; ex_idx_i = i;
        ex_pos_i = p;    ex_typ_i = t;   ex_tar_i = a;
    endtask

    task automatic expect_wr(input logic [IW-1:0] i, input logic v,
                             input logic [2:0] p, input logic [1:0] t,
                             input logic [63:0] a, input int due);
        exp_t x;
        x = '{i, v, p, t, a, due};
        sb.push_back(x);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk(name, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        sb.delete();
    endtask

    vec_t tbl[6];

    initial begin
        int acc;
        int stall_at;
        int n0;
        int guard;
        int base;
        logic r;

        tbl[0] = '{1'b0, 1'b0, 6'd5,  3'd3, 2'd2, 64'h1000, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 6'd9,  3'd0, 2'd1, 64'hdead_beef_0000_0040, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 6'd63, 3'd7, 2'd3, 64'hffff_ffff_ffff_fffc, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 6'd0,  3'd7, 2'd0, 64'h8000_0000_0000_0000, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 6'd42, 3'd1, 2'd3, 64'h0123_4567_89ab_cdef, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 6'd17, 3'd4, 2'd0, 64'h0, 1'b1};

        idle();
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_we", 64'(btb_we_o), 64'd0);
        chk("rst_rdy", 64'(ex_rdy_o), 64'd1);
        chk("rst_full", 64'(fifo_full_o), 64'd0);
        chk("rst_idx", 64'(btb_idx_o), 64'd0);
        chk("rst_vld", 64'(btb_vld_o), 64'd0);
        chk("rst_tar", btb_tar_o, 64'd0);
`ifdef BTB_WR_ARB_STATS_EN
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("rst_kill", 64'(kill_cnt_o), 64'd0);
`endif
        do_reset();

        // Idle-port vectors: each write must appear exactly two cycles on.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].is_ex)
                ex(tbl[i].inv, tbl[i].idx, tbl[i].pos, tbl[i].typ, tbl[i].tar);
            else
                fe(tbl[i].idx, tbl[i].pos, tbl[i].typ, tbl[i].tar);
            expect_wr(tbl[i].idx, tbl[i].exp_vld, tbl[i].pos,
                      tbl[i].typ, tbl[i].tar, cyc + 2);
            tick();
            idle();
            repeat (3) tick();
            chk("tbl_drain", 64'(sb.size()), 64'd0);
        end
        sb.delete();

        // Stale kill: queued fe idx=1 invalidated by ex before draining.
        do_reset();
        btb_rd_i = 1'b1;
        fe(6'd1, 3'd2, 2'd1, 64'h2000);
        tick();
        fe_we_i = 1'b0;
        ex(1'b1, 6'd1, 3'd0, 2'd0, 64'h0);
        expect_wr(6'd1, 1'b0, 3'd0, 2'd0, 64'h0, -1);
        tick();
        idle();
        drain("kill_drain", 20);
`ifdef BTB_WR_ARB_STATS_EN
        chk("kill_cnt", 64'(kill_cnt_o), 64'd1);
        chk("kill_drop", 64'(drop_cnt_o), 64'd0);
`endif
        fe(6'd3, 3'd1, 2'd2, 64'h3000);
        ex(1'b0, 6'd3, 3'd5, 2'd3, 64'h3300);
        expect_wr(6'd3, 1'b1, 3'd5, 2'd3, 64'h3300, cyc + 2);
        tick();
        idle();
        drain("same_kill_drain", 20);
`ifdef BTB_WR_ARB_STATS_EN
        chk("same_kill_drop", 64'(drop_cnt_o), 64'd1);
`endif

        // Port held by reads: fill FIFO, drop the 5th, stall ex.
        do_reset();
        btb_rd_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fe(IW'(10 + i), 3'(i), 2'(i), 64'h100 * i);
            tick();
        end
        fe_we_i = 1'b0;
        chk("rd_full", 64'(fifo_full_o), 64'd1);
        ex(1'b0, 6'd30, 3'd6, 2'd1, 64'h7700);
        tick();
        ex_vld_i = 1'b0;
        chk("rd_ex_rdy", 64'(ex_rdy_o), 64'd0);
        repeat (4) tick();
        chk("rd_still_full", 64'(fifo_full_o), 64'd1);
        chk("rd_ex_rdy_held", 64'(ex_rdy_o), 64'd0);
        btb_rd_i = 1'b0;
        expect_wr(6'd10, 1'b1, 3'd0, 2'd0, 64'h0,   cyc + 1);
        expect_wr(6'd30, 1'b1, 3'd6, 2'd1, 64'h7700, cyc + 2);
        expect_wr(6'd11, 1'b1, 3'd1, 2'd1, 64'h100, cyc + 3);
        expect_wr(6'd12, 1'b1, 3'd2, 2'd2, 64'h200, cyc + 4);
        expect_wr(6'd13, 1'b1, 3'd3, 2'd3, 64'h300, cyc + 5);
        drain("rd_drain", 20);
`ifdef BTB_WR_ARB_STATS_EN
        chk("rd_drop", 64'(drop_cnt_o), 64'd1);
`endif

        // Starvation: steady ex traffic, FIFO head forced out at count 7.
        do_reset();
        n0 = cyc;
        fe(6'd10, 3'd2, 2'd2, 64'hf00);
        acc = 0;
        stall_at = -1;
        guard = 0;
        ex(1'b0, 6'd20, 3'd0, 2'd0, 64'h4000);
        while (acc < 10 && guard < 40) begin
            @(negedge clk);
            r = ex_rdy_o;
            tick();
            fe_we_i = 1'b0;
            guard++;
            if (r) begin
                if (acc == 7)
                    expect_wr(6'd10, 1'b1, 3'd2, 2'd2, 64'hf00, n0 + 9);
                expect_wr(IW'(20 + acc), 1'b1, 3'(acc), 2'(acc),
                          64'h4000 + 64'(acc * 4), -1);
                acc++;
                if (acc < 10)
                    ex(1'b0, IW'(20 + acc), 3'(acc), 2'(acc),
                       64'h4000 + 64'(acc * 4));
                else
                    ex_vld_i = 1'b0;
            end else if (stall_at < 0) begin
                stall_at = acc;
            end
        end
        idle();
        chk("starve_accepts", 64'(acc), 64'd10);
        chk("starve_grant_at", 64'(stall_at), 64'd8);
        drain("starve_drain", 20);

        // Flush with 3 queued entries and a held ex write.
        do_reset();
        btb_rd_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fe(IW'(1 + i), 3'd0, 2'd0, 64'h500 + 64'(i));
            tick();
        end
        fe_we_i = 1'b0;
        ex(1'b0, 6'd40, 3'd4, 2'd2, 64'h4040);
        tick();
        ex_vld_i = 1'b0;
        btb_rd_i = 1'b0;
        flush_i = 1'b1;
        fe(6'd50, 3'd1, 2'd1, 64'h5050);
        expect_wr(6'd40, 1'b1, 3'd4, 2'd2, 64'h4040, cyc + 1);
        tick();
        idle();
        chk("flush_full", 64'(fifo_full_o), 64'd0);
        drain("flush_drain", 10);
        btb_rd_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fe(IW'(4 + i), 3'(i), 2'd1, 64'h600 + 64'(i));
            tick();
            if (i == 2)
                chk("flush_refill3", 64'(fifo_full_o), 64'd0);
        end
        fe_we_i = 1'b0;
        chk("flush_refill4", 64'(fifo_full_o), 64'd1);
        btb_rd_i = 1'b0;
        for (int i = 0; i < 4; i++)
            expect_wr(IW'(4 + i), 1'b1, 3'(i), 2'd1,
                      64'h600 + 64'(i), cyc + 1 + i);
        drain("refill_drain", 20);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        btb_rd_i = 1'b1;
        fe(6'd11, 3'd1, 2'd0, 64'hb0);
        tick();
        fe(6'd12, 3'd2, 2'd0, 64'hc0);
        tick();
        fe_we_i = 1'b0;
        ex(1'b0, 6'd13, 3'd3, 2'd1, 64'hd0);
        tick();
        ex_vld_i = 1'b0;
        chk("mid_rdy_pre", 64'(ex_rdy_o), 64'd0);
        btb_rd_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("mid_rst_we", 64'(btb_we_o), 64'd0);
        chk("mid_rst_idx", 64'(btb_idx_o), 64'd0);
        chk("mid_rst_tar", btb_tar_o, 64'd0);
        chk("mid_rst_rdy", 64'(ex_rdy_o), 64'd1);
        repeat (2) tick();
        rst_i = 1'b0;
        base = wr_seen;
        repeat (10) tick();
        chk("mid_post_writes", 64'(wr_seen - base), 64'd0);
        chk("mid_post_full", 64'(fifo_full_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
